// File: rtl/puntaje_pkg.sv
// Shared game-state encodings, bonus ladder, and display helpers for the score unit.
package puntaje_pkg;

   localparam logic [2:0] OFF  = 3'd0;
   localparam logic [2:0] WLCM = 3'd1;
   localparam logic [2:0] CH   = 3'd2;
   localparam logic [2:0] GAME = 3'd3;
   localparam logic [2:0] WL   = 3'd4;
   localparam logic [2:0] PA   = 3'd5;

   typedef enum logic [1:0] {
      CV_IDLE  = 2'd0,
      CV_SHIFT = 2'd1,
      CV_DONE  = 2'd2
   } conv_state_t;

   // Bonus ladder {10, 30, 45, 60}; indices past the table give nothing.
   function automatic logic [6:0] bonus_table(input logic [2:0] idx);
      case (idx)
         3'd0:    bonus_table = 7'd10;
         3'd1:    bonus_table = 7'd30;
         3'd2:    bonus_table = 7'd45;
         3'd3:    bonus_table = 7'd60;
         default: bonus_table = 7'd0;
      endcase
   endfunction

   function automatic int score_max(input int digits);
      int r;
      r = 32'sd1;
      for (int i = 0; i < digits; i++) r = r * 32'sd10;
      return r - 32'sd1;
   endfunction

   // Segment order is {g,f,e,d,c,b,a}.
   function automatic logic [6:0] bcd_to_7seg(input logic [3:0] d);
      case (d)
         4'd0:    bcd_to_7seg = 7'b0111111;
         4'd1:    bcd_to_7seg = 7'b0000110;
         4'd2:    bcd_to_7seg = 7'b1011011;
         4'd3:    bcd_to_7seg = 7'b1001111;
         4'd4:    bcd_to_7seg = 7'b1100110;
         4'd5:    bcd_to_7seg = 7'b1101101;
         4'd6:    bcd_to_7seg = 7'b1111101;
         4'd7:    bcd_to_7seg = 7'b0000111;
         4'd8:    bcd_to_7seg = 7'b1111111;
         4'd9:    bcd_to_7seg = 7'b1101111;
         default: bcd_to_7seg = 7'b0000000;
      endcase
   endfunction

endpackage

// File: rtl/puntaje_gen_bin2bcd.sv
// Sequential double-dabble converter: one shift/add-3 step per cycle,
// result published atomically when the last step completes.
module bin2bcd_seq
   import puntaje_pkg::*;
#(
   parameter int W      = 10,
   parameter int DIGITS = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [W-1:0]        bin,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] bcd
);

   localparam int CW = $clog2(W + 1);
   localparam int BW = 4 * DIGITS;

   conv_state_t   state_r;
   logic [W-1:0]  sh_r;
   logic [BW-1:0] scr_r;
   logic [BW-1:0] adj_s;
   logic [BW-1:0] nxt_s;
   logic [BW-1:0] bcd_r;
   logic [CW-1:0] step_r;
   logic          done_r;

   // Add-3 correction on every digit >= 5, then shift in the next binary bit.
   always_comb begin
      adj_s = scr_r;
      for (int d = 0; d < DIGITS; d++) begin
         if (scr_r[4*d +: 4] >= 4'd5) adj_s[4*d +: 4] = scr_r[4*d +: 4] + 4'd3;
         else                         adj_s[4*d +: 4] = scr_r[4*d +: 4];
      end
      nxt_s = {adj_s[BW-2:0], sh_r[W-1]};
   end

   // Idle / shift / done sequencer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= CV_IDLE;
         sh_r    <= '0;
         scr_r   <= '0;
         step_r  <= '0;
         bcd_r   <= '0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            CV_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  sh_r    <= bin;
                  scr_r   <= '0;
                  step_r  <= '0;
                  state_r <= CV_SHIFT;
               end
            end
            CV_SHIFT: begin
               scr_r  <= nxt_s;
               sh_r   <= {sh_r[W-2:0], 1'b0};
               step_r <= step_r + CW'(1);
               if (step_r == CW'(W - 1)) begin
                  bcd_r   <= nxt_s;
                  done_r  <= 1'b1;
                  state_r <= CV_DONE;
               end
            end
            CV_DONE: begin
               done_r  <= 1'b0;
               state_r <= CV_IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               state_r <= CV_IDLE;
            end
         endcase
      end
   end

   assign busy = (state_r != CV_IDLE);
   assign done = done_r;
   assign bcd  = bcd_r;

endmodule

// File: rtl/puntaje_gen.sv
// Saturating game score with bonus ladder and session record; both values are
// converted to BCD in the background and shown on two 7-segment banks.
module puntaje_gen
   import puntaje_pkg::*;
#(
   parameter int TICK_DIV = 27000000,
   parameter int DIGITS   = 3,
   parameter int SCORE_W  = 10,
   parameter int BONUS_N  = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2:0]           presente,
   input  logic [1:0]           W_or_L,
   input  logic                 bono_tomado,
   output logic [SCORE_W-1:0]   puntaje_bin,
   output logic [SCORE_W-1:0]   record_bin,
   output logic [7*DIGITS-1:0]  display_puntaje,
   output logic [7*DIGITS-1:0]  display_record,
   output logic                 nuevo_record
);

   localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW1  = SCORE_W + 1;
   localparam int SMAX = score_max(DIGITS);
   localparam int BW   = 4 * DIGITS;
   localparam int DW   = 7 * DIGITS;

   logic [TW-1:0]      tcnt_r;
   logic               tick_s;
   logic               playing_s;
   logic               bono_prev_r;
   logic               bono_ok_s;
   logic [2:0]         bidx_r;
   logic [2:0]         prev_st_r;
   logic [SCORE_W-1:0] score_r;
   logic [SCORE_W-1:0] record_r;
   logic               nuevo_r;
   logic [SW1-1:0]     sum_s;
   logic [SW1-1:0]     sat_s;
   logic [SCORE_W-1:0] last_p_r, last_r_r;
   logic               start_p_s, start_r_s;
   logic               busy_p_s, busy_r_s, done_p_s, done_r_s;
   logic [BW-1:0]      bcd_p_s, bcd_r_s;
   logic [DW-1:0]      seg_p_s, seg_r_s;
   logic [DW-1:0]      disp_p_r, disp_r_r;

   assign playing_s = (presente == GAME) && (W_or_L == 2'b00);
   assign tick_s    = (presente == GAME) && (tcnt_r == TW'(TICK_DIV - 1));
   assign bono_ok_s = bono_tomado && !bono_prev_r && playing_s && (bidx_r < 3'(BONUS_N));

   // Tick and bonus merge into one widened sum, clamped to the display range.
   always_comb begin
      sum_s = {1'b0, score_r};
      if (tick_s) sum_s = sum_s + SW1'(1);
      else        sum_s = sum_s;
      if (bono_ok_s) sum_s = sum_s + SW1'(bonus_table(bidx_r));
      else           sum_s = sum_s;
      if (sum_s > SW1'(SMAX)) sat_s = SW1'(SMAX);
      else                    sat_s = sum_s;
   end

   // Time-point divider: runs in GAME, frozen in PA, cleared elsewhere.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt_r <= '0;
      end else begin
         case (presente)
            GAME:    tcnt_r <= tick_s ? '0 : tcnt_r + TW'(1);
            PA:      tcnt_r <= tcnt_r;
            default: tcnt_r <= '0;
         endcase
      end
   end

   // Score, bonus index and edge/state history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         score_r     <= '0;
         bidx_r      <= 3'd0;
         bono_prev_r <= 1'b0;
         prev_st_r   <= OFF;
      end else begin
         bono_prev_r <= bono_tomado;
         prev_st_r   <= presente;
         case (presente)
            GAME: begin
               if (playing_s) score_r <= sat_s[SCORE_W-1:0];
               if (bono_ok_s) bidx_r <= bidx_r + 3'd1;
            end
            WL, PA: begin
               score_r <= score_r;
               bidx_r  <= bidx_r;
            end
            default: begin
               score_r <= '0;
               bidx_r  <= 3'd0;
            end
         endcase
      end
   end

   // Record is only judged on the GAME -> WL transition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         record_r <= '0;
         nuevo_r  <= 1'b0;
      end else if ((presente == WL) && (prev_st_r == GAME)) begin
         if (score_r > record_r) begin
            record_r <= score_r;
            nuevo_r  <= 1'b1;
         end
      end else if (presente != WL) begin
         nuevo_r <= 1'b0;
      end
   end

   assign start_p_s = !busy_p_s && (score_r != last_p_r);
   assign start_r_s = !busy_r_s && (record_r != last_r_r);

   // Remember the value each converter was last launched with.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_p_r <= '0;
         last_r_r <= '0;
      end else begin
         if (start_p_s) last_p_r <= score_r;
         if (start_r_s) last_r_r <= record_r;
      end
   end

   bin2bcd_seq #(.W(SCORE_W), .DIGITS(DIGITS)) u_bcd_puntaje (
      .clk(clk), .rst(rst), .start(start_p_s), .bin(score_r),
      .busy(busy_p_s), .done(done_p_s), .bcd(bcd_p_s)
   );

   bin2bcd_seq #(.W(SCORE_W), .DIGITS(DIGITS)) u_bcd_record (
      .clk(clk), .rst(rst), .start(start_r_s), .bin(record_r),
      .busy(busy_r_s), .done(done_r_s), .bcd(bcd_r_s)
   );

   // Most significant digit goes to the lowest segment slice.
   always_comb begin
      seg_p_s = '0;
      seg_r_s = '0;
      for (int d = 0; d < DIGITS; d++) begin
         seg_p_s[7*(DIGITS-1-d) +: 7] = bcd_to_7seg(bcd_p_s[4*d +: 4]);
         seg_r_s[7*(DIGITS-1-d) +: 7] = bcd_to_7seg(bcd_r_s[4*d +: 4]);
      end
   end

   // Display banks latch only on a finished conversion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_p_r <= {DIGITS{7'b0111111}};
         disp_r_r <= {DIGITS{7'b0111111}};
      end else begin
         if (done_p_s) disp_p_r <= seg_p_s;
         if (done_r_s) disp_r_r <= seg_r_s;
      end
   end

   assign puntaje_bin     = score_r;
   assign record_bin      = record_r;
   assign nuevo_record    = nuevo_r;
   assign display_puntaje = disp_p_r;
   assign display_record  = disp_r_r;

endmodule
